idex_stage: RTL
===============

Name: idex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.
- Captures decoded instructions from the decode stage and resolves forwarding from the MEM and WB stages.
- Selects the immediate for the y operand when requested.
- Detects load-use hazards and presents registered x, y and funct to the ALU.
- Uses a valid/ready handshake on both sides, plus a synchronous flush for branch redirect.

Parameters:
N, 32, datapath width (x, y, imm, forwarded data)
FUNCT_W, `ALU_FUNCT_WIDTH, ALU function code width (from shared defines)
REG_AW, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the EX slot and refusal of decode this cycle
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_rs1, id_rs2  in  REG_AW  source register addresses
id_rs1_data, id_rs2_data  in  N  register-file read data
id_imm  in  N  sign-extended immediate
id_use_imm  in  1  y operand = id_imm instead of rs2
id_funct  in  FUNCT_W  ALU function code
id_rd  in  REG_AW  destination register
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
mem_fwd_we, wb_fwd_we  in  1  stage holds a valid register write
mem_fwd_rd, wb_fwd_rd  in  REG_AW  destination of that write
mem_fwd_data, wb_fwd_data  in  N  value being written
ex_valid  out  1  EX slot holds a live instruction
ex_ready  in  1  ALU/EX consumer accepts the slot
ex_x, ex_y  out  N  ALU operands
ex_funct  out  FUNCT_W  ALU function
ex_rd  out  REG_AW  destination register
ex_rd_we  out  1  write enable, passed through
ex_is_load  out  1  load flag, passed through
ex_rs2_data  out  N  forwarded rs2 value (store data path)
hazard_stall  out  1  load-use stall is active (for performance counter and debug)

Behaviour:
- Reset: every output register is 0; ex_valid=0. id_ready is combinational and is 1 after reset.
- Slot states:
  - EMPTY: ex_valid=0.
  - FULL: ex_valid=1.
  - The stall condition is derived combinationally, not held in a separate state.
- hazard = ex_valid & ex_is_load & ex_rd_we & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (!id_use_imm & ex_rd==id_rs2)).
  - hazard_stall = hazard.
- id_ready = !flush & !hazard & (!ex_valid | ex_ready).
- Capture happens when id_valid & id_ready; the slot becomes FULL with the new instruction next cycle. Latency is 1 cycle from decode acceptance to the operands at the ALU.
- EX consumed with no capture (ex_valid & ex_ready, no capture): slot → EMPTY.
  - This includes the hazard cycle, which therefore inserts exactly one bubble.
- ex_valid & !ex_ready: all ex_* outputs hold their values, bit-exact.
- flush=1: next cycle ex_valid=0, regardless of ex_ready or id_valid. The data fields may keep stale values.
  - flush takes priority over capture and hazard.
- Forwarding for each source operand rs (applied at capture):
  - Priority: mem_fwd, then wb_fwd, then register-file data.
  - A source matches only if its we=1 and its rd==rs.
  - rs==0 always yields 0 and is never forwarded.
- ex_y = id_use_imm ? id_imm : fwd(rs2).
- ex_rs2_data = fwd(rs2) always.
- ex_x = fwd(rs1).
- No arithmetic is performed in this block; all data is passed at full N bits.
- Reset asserted mid-operation clears the slot immediately (asynchronously).
- Simultaneous capture and consume in the same cycle is a back-to-back transfer with no bubble.

Decomposition:
- Shared defines header (existing ALU funct header): ALU_FUNCT_WIDTH and the funct codes. Add REG_AW and a ZERO_REG constant.
- One natural sub-module: fwd_mux (combinational, instantiated twice). It selects among mem, wb and regfile data and handles the x0 rule.

Test Plan:
- Plain flow: ADD with rs1_data=5, rs2_data=7, ex_ready=1 → next cycle ex_valid=1, ex_x=5, ex_y=7, ex_funct=ADD. Back-to-back instructions each advance in 1 cycle with no bubbles.
- Forward priority: rs1=3, mem_fwd(rd=3, data=0xAA) and wb_fwd(rd=3, data=0xBB) both active, regfile=0x11 → ex_x=0xAA. With mem_fwd_we=0 → 0xBB. With rs1=0 and both forwarding to rd=0 → ex_x=0.
- Load-use: EX holds a load with rd=4; decode presents ADD with rs1=4 → id_ready=0 and hazard_stall=1 for 1 cycle, followed by a bubble (ex_valid=0). The next cycle captures with wb_fwd data.
  - Same case with id_use_imm=1 and rs2=4 (rs1≠4) → no stall.
- Backpressure: ex_ready=0 for 3 cycles with the slot FULL → ex_* stable and id_ready=0. Release → the held instruction is consumed, and the next instruction is captured in the same cycle.
- Flush: flush=1 while id_valid=1, slot FULL, ex_ready=0 → next cycle ex_valid=0 and the decode instruction is not accepted.
- Async reset: drop rst_n mid-cycle while FULL → ex_valid=0 and outputs=0 before the next clock edge. Release → normal capture resumes.

Source files
------------

// File: rtl/idex_stage_pkg.sv
// rtl/idex_stage_pkg.sv - shared ALU function codes, register-address width and slot states
package idex_stage_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;
    localparam int REG_AW          = 5;

    // Architectural x0: reads as zero and is never a forwarding target
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_funct_e;

    // Occupancy of the single EX slot
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// rtl/idex_stage_fwd_mux.sv - operand forwarding select (mem > wb > regfile, x0 forced to zero)
module fwd_mux #(
    parameter int N      = 32,
    parameter int REG_AW = idex_stage_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [N-1:0]      i_rf_data,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [N-1:0]      i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [N-1:0]      i_wb_data,
    output logic [N-1:0]      o_data
);
    import idex_stage_pkg::*;

    // The younger MEM result wins over WB; x0 never picks up a forwarded value
    always_comb begin
        o_data = i_rf_data;
        if (i_rs == REG_AW'(ZERO_REG)) begin
            o_data = '0;
        end else if (i_mem_we && (i_mem_rd == i_rs)) begin
            o_data = i_mem_data;
        end else if (i_wb_we && (i_wb_rd == i_rs)) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with forwarding, immediate select and load-use stall
module idex_stage #(
    parameter int N       = 32,
    parameter int FUNCT_W = idex_stage_pkg::ALU_FUNCT_WIDTH,
    parameter int REG_AW  = idex_stage_pkg::REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [N-1:0]       id_rs1_data,
    input  logic [N-1:0]       id_rs2_data,
    input  logic [N-1:0]       id_imm,
    input  logic               id_use_imm,
    input  logic [FUNCT_W-1:0] id_funct,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_rd_we,
    input  logic               id_is_load,
    input  logic               mem_fwd_we,
    input  logic [REG_AW-1:0]  mem_fwd_rd,
    input  logic [N-1:0]       mem_fwd_data,
    input  logic               wb_fwd_we,
    input  logic [REG_AW-1:0]  wb_fwd_rd,
    input  logic [N-1:0]       wb_fwd_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [N-1:0]       ex_x,
    output logic [N-1:0]       ex_y,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_rd_we,
    output logic               ex_is_load,
    output logic [N-1:0]       ex_rs2_data,
    output logic               hazard_stall
);
    import idex_stage_pkg::*;

    slot_e               r_slot;
    slot_e               w_slot_nxt;
    logic [N-1:0]        r_x;
    logic [N-1:0]        r_y;
    logic [FUNCT_W-1:0]  r_funct;
    logic [REG_AW-1:0]   r_rd;
    logic                r_rd_we;
    logic                r_is_load;
    logic [N-1:0]        r_rs2_data;

    logic [N-1:0]        w_rs1_fwd;
    logic [N-1:0]        w_rs2_fwd;
    logic                w_hazard;
    logic                w_ready;
    logic                w_capture;
    logic                w_ex_valid;

    fwd_mux #(.N(N), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_rs       (id_rs1),
        .i_rf_data  (id_rs1_data),
        .i_mem_we   (mem_fwd_we),
        .i_mem_rd   (mem_fwd_rd),
        .i_mem_data (mem_fwd_data),
        .i_wb_we    (wb_fwd_we),
        .i_wb_rd    (wb_fwd_rd),
        .i_wb_data  (wb_fwd_data),
        .o_data     (w_rs1_fwd)
    );

    fwd_mux #(.N(N), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_rs       (id_rs2),
        .i_rf_data  (id_rs2_data),
        .i_mem_we   (mem_fwd_we),
        .i_mem_rd   (mem_fwd_rd),
        .i_mem_data (mem_fwd_data),
        .i_wb_we    (wb_fwd_we),
        .i_wb_rd    (wb_fwd_rd),
        .i_wb_data  (wb_fwd_data),
        .o_data     (w_rs2_fwd)
    );

    assign w_ex_valid = (r_slot == SLOT_FULL);

    // Load-use detection and decode-side handshake; rs2 only matters when it feeds y
    always_comb begin
        w_hazard = w_ex_valid && r_is_load && r_rd_we && (r_rd != REG_AW'(ZERO_REG)) && id_valid &&
                   ((r_rd == id_rs1) || (!id_use_imm && (r_rd == id_rs2)));
        w_ready   = !flush && !w_hazard && (!w_ex_valid || ex_ready);
        w_capture = id_valid && w_ready;
    end

    // Slot occupancy register; async clear drops the slot immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= SLOT_EMPTY;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    // Next slot state: flush kills, capture fills, a consume without refill drains
    always_comb begin
        w_slot_nxt = r_slot;
        if (flush) begin
            w_slot_nxt = SLOT_EMPTY;
        end else if (w_capture) begin
            w_slot_nxt = SLOT_FULL;
        end else if (w_ex_valid && ex_ready) begin
            w_slot_nxt = SLOT_EMPTY;
        end
    end

    // Operand/control payload loads only on capture so a stalled slot stays bit-exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_funct    <= '0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
            r_rs2_data <= '0;
        end else if (w_capture) begin
            r_x        <= w_rs1_fwd;
            r_y        <= id_use_imm ? id_imm : w_rs2_fwd;
            r_funct    <= id_funct;
            r_rd       <= id_rd;
            r_rd_we    <= id_rd_we;
            r_is_load  <= id_is_load;
            r_rs2_data <= w_rs2_fwd;
        end
    end

    assign id_ready     = w_ready;
    assign hazard_stall = w_hazard;
    assign ex_valid     = w_ex_valid;
    assign ex_x         = r_x;
    assign ex_y         = r_y;
    assign ex_funct     = r_funct;
    assign ex_rd        = r_rd;
    assign ex_rd_we     = r_rd_we;
    assign ex_is_load   = r_is_load;
    assign ex_rs2_data  = r_rs2_data;

endmodule
